rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_wport_arb.sv | 186 ++++++++++++++++++
 tb/tb_rf_wport_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: two-requester write-port arbiter for a register file.
//
// Requester A (ALU writeback) and requester B (load writeback) each own one
// holding register. Each cycle at most one full holding register is granted
// and its contents are registered onto the RF write port (we/dst_addr/dst).
// Writes to register 0 are consumed but never drive we.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_vld/a_addr/a_data      requester A offer;  a_rdy handshake output
//   b_vld/b_addr/b_data      requester B offer;  b_rdy handshake output
//   we, dst_addr, dst        registered RF write port
//   rd_addr0, rd_addr1       decode-stage read addresses for hazard check
//   stall                    a read address hits a held (not yet driven) write
//   hlt                      stop accepting, keep draining
//   idle                     nothing held and we low
//   conf_cnt                 saturating count of cycles with both entries full
module rf_wport_arb #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_vld,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_rdy,
  input  logic          b_vld,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_rdy,
  output logic          we,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic          stall,
  input  logic          hlt,
  output logic          idle,
  output logic [7:0]    conf_cnt
);

  typedef enum logic {ReqA = 1'b0, ReqB = 1'b1} req_e;

  // Holding registers
  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [DW-1:0] b_data_q, b_data_d;

  // Arbitration state: round-robin pointer and "which entry is older"
  req_e rr_q, rr_d;
  req_e age_q, age_d;

  // Write port and statistics
  logic          we_q, we_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [DW-1:0] dst_q, dst_d;
  logic [7:0]    conf_q, conf_d;

  logic both_full;
  logic same_addr;
  logic grant_a, grant_b;
  logic a_acc, b_acc;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Grant selection
  always_comb begin
    both_full = a_full_q & b_full_q;
    // Same-address conflicts are ordered by age so the younger write lands last;
    // register 0 writes carry no ordering meaning and fall back to round-robin.
    same_addr = both_full & (a_addr_q == b_addr_q) & (a_addr_q != '0);
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (both_full) begin
      if (same_addr) begin
        if (age_q == ReqA) grant_a = 1'b1;
        else               grant_b = 1'b1;
      end else begin
        if (rr_q == ReqA) grant_a = 1'b1;
        else              grant_b = 1'b1;
      end
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  // A draining entry can be refilled on the same edge.
  assign a_rdy = rst_n & ~hlt & (~a_full_q | grant_a);
  assign b_rdy = rst_n & ~hlt & (~b_full_q | grant_b);
  assign a_acc = a_vld & a_rdy;
  assign b_acc = b_vld & b_rdy;

  // Holding-register and arbitration next state
  always_comb begin
    a_full_d = a_acc | (a_full_q & ~grant_a);
    a_addr_d = a_acc ? a_addr : a_addr_q;
    a_data_d = a_acc ? a_data : a_data_q;
    b_full_d = b_acc | (b_full_q & ~grant_b);
    b_addr_d = b_acc ? b_addr : b_addr_q;
    b_data_d = b_acc ? b_data : b_data_q;

    // Whoever loads alone becomes the younger entry; simultaneous loads treat A
    // as older.
    age_d = age_q;
    if (a_acc & b_acc)  age_d = ReqA;
    else if (a_acc)     age_d = ReqB;
    else if (b_acc)     age_d = ReqA;

    rr_d = rr_q;
    if (both_full & ~same_addr) rr_d = grant_a ? ReqB : ReqA;

    conf_d = conf_q;
    if (both_full && (conf_q != 8'hFF)) conf_d = conf_q + 8'd1;
  end

  // Write-port next state
  always_comb begin
    sel_addr   = grant_b ? b_addr_q : a_addr_q;
    sel_data   = grant_b ? b_data_q : a_data_q;
    we_d       = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_d      = dst_q;
    // Register 0 is hard-wired: consume the entry, but keep the port quiet.
    if ((grant_a | grant_b) && (sel_addr != '0)) begin
      we_d       = 1'b1;
      dst_addr_d = sel_addr;
      dst_d      = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q   <= 1'b0;
      a_addr_q   <= '0;
      a_data_q   <= '0;
      b_full_q   <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= '0;
      rr_q       <= ReqA;
      age_q      <= ReqA;
      we_q       <= 1'b0;
      dst_addr_q <= '0;
      dst_q      <= '0;
      conf_q     <= '0;
    end else begin
      a_full_q   <= a_full_d;
      a_addr_q   <= a_addr_d;
      a_data_q   <= a_data_d;
      b_full_q   <= b_full_d;
      b_addr_q   <= b_addr_d;
      b_data_q   <= b_data_d;
      rr_q       <= rr_d;
      age_q      <= age_d;
      we_q       <= we_d;
      dst_addr_q <= dst_addr_d;
      dst_q      <= dst_d;
      conf_q     <= conf_d;
    end
  end

  // Hazard check covers held entries only; a write already on the port lands
  // in the RF before the decode-stage read of the same cycle.
  always_comb begin
    stall = 1'b0;
    if (rd_addr0 != '0) begin
      if (a_full_q && (a_addr_q == rd_addr0)) stall = 1'b1;
      if (b_full_q && (b_addr_q == rd_addr0)) stall = 1'b1;
    end
    if (rd_addr1 != '0) begin
      if (a_full_q && (a_addr_q == rd_addr1)) stall = 1'b1;
      if (b_full_q && (b_addr_q == rd_addr1)) stall = 1'b1;
    end
  end

  assign we       = we_q;
  assign dst_addr = dst_addr_q;
  assign dst      = dst_q;
  assign conf_cnt = conf_q;
  assign idle     = ~a_full_q & ~b_full_q & ~we_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed scenarios plus randomized
// traffic, compared every cycle against a timestamp-based reference model.
module tb_rf_wport_arb;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_vld, b_vld, hlt;
  logic [AW-1:0] a_addr, b_addr, rd_addr0, rd_addr1;
  logic [DW-1:0] a_data, b_data;
  logic          a_rdy, b_rdy, we, stall, idle;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst;
  logic [7:0]    conf_cnt;

  always #5 clk = ~clk;

  rf_wport_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_vld(a_vld), .a_addr(a_addr), .a_data(a_data), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_addr(b_addr), .b_data(b_data), .b_rdy(b_rdy),
    .we(we), .dst_addr(dst_addr), .dst(dst),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .stall(stall),
    .hlt(hlt), .idle(idle), .conf_cnt(conf_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: entry 0 = A, entry 1 = B. Age is a load timestamp.
  bit            m_full[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  int            m_stamp[2];
  int            m_rr;
  bit            m_we;
  logic [AW-1:0] m_dst_addr;
  logic [DW-1:0] m_dst;
  int            m_conf;
  int            cyc;
  logic [DW-1:0] dut_rf[16];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_stamp[i] = 0;
    end
    m_rr = 0; m_we = 0; m_dst_addr = '0; m_dst = '0; m_conf = 0;
  endtask

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1] && m_addr[0] != 0)
        return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
      return m_rr;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_rdy(input int i);
    return rst_n && !hlt && (!m_full[i] || m_grant() == i);
  endfunction

  function automatic bit m_hit(input logic [AW-1:0] ra);
    if (ra == 0) return 0;
    for (int i = 0; i < 2; i++) if (m_full[i] && m_addr[i] == ra) return 1;
    return 0;
  endfunction

  task automatic model_compare();
    check_val("we", we, m_we);
    check_val("dst_addr", dst_addr, m_dst_addr);
    check_val("dst", dst, m_dst);
    check_val("conf_cnt", conf_cnt, m_conf);
    check_val("a_rdy", a_rdy, m_rdy(0));
    check_val("b_rdy", b_rdy, m_rdy(1));
    check_val("stall", stall, m_hit(rd_addr0) || m_hit(rd_addr1));
    check_val("idle", idle, !m_full[0] && !m_full[1] && !m_we);
  endtask

  // Drive inputs after the falling edge, then compare against the model.
  task automatic dc(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                    input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                    input bit h, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    a_vld = av; a_addr = aa; a_data = ad;
    b_vld = bv; b_addr = ba; b_data = bd;
    hlt = h; rd_addr0 = r0; rd_addr1 = r1;
    #1;
    model_compare();
    if (we) dut_rf[dst_addr] = dst;
  endtask

  task automatic dc_idle();
    dc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model across a rising edge.
  task automatic step();
    int  g;
    bit  acc[2];
    @(posedge clk);
    g = m_grant();
    acc[0] = a_vld && m_rdy(0);
    acc[1] = b_vld && m_rdy(1);
    if (m_full[0] && m_full[1]) begin
      if (m_conf < 255) m_conf++;
      if (!(m_addr[0] == m_addr[1] && m_addr[0] != 0)) m_rr = 1 - g;
    end
    m_we = 0;
    if (g >= 0) begin
      if (m_addr[g] != 0) begin
        m_we = 1; m_dst_addr = m_addr[g]; m_dst = m_data[g];
      end
      m_full[g] = 0;
    end
    if (acc[0]) begin
      m_full[0] = 1; m_addr[0] = a_addr; m_data[0] = a_data; m_stamp[0] = 2 * cyc;
    end
    if (acc[1]) begin
      m_full[1] = 1; m_addr[1] = b_addr; m_data[1] = b_data; m_stamp[1] = 2 * cyc + 1;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      dc_idle(); step();
    end
  endtask

  initial begin
    cyc = 0;
    rst_n = 1'b0;
    a_vld = 0; a_addr = '0; a_data = '0;
    b_vld = 0; b_addr = '0; b_data = '0;
    hlt = 0; rd_addr0 = '0; rd_addr1 = '0;
    for (int i = 0; i < 16; i++) dut_rf[i] = '0;
    model_reset();
    #2;
    check_val("rst_a_rdy", a_rdy, 0);
    check_val("rst_b_rdy", b_rdy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    dc_idle();
    check_val("post_rst_we", we, 0);
    check_val("post_rst_idle", idle, 1);
    check_val("post_rst_conf", conf_cnt, 0);
    check_val("post_rst_a_rdy", a_rdy, 1);
    check_val("post_rst_b_rdy", b_rdy, 1);
    step();

    // Single write
    dc(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0); step();
    dc(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check_val("single_stall", stall, 1);
    step();
    dc_idle();
    check_val("single_we", we, 1);
    check_val("single_addr", dst_addr, 3);
    check_val("single_data", dst, 16'h1234);
    step();
    idle_cycles(2);

    // Conflict, different addresses, twice
    dc(1, 5, 16'hAAAA, 1, 6, 16'hBBBB, 0, 0, 0); step();
    dc_idle(); step();
    dc_idle();
    check_val("conf1_first_addr", dst_addr, 5);
    check_val("conf1_first_data", dst, 16'hAAAA);
    check_val("conf1_cnt", conf_cnt, 1);
    step();
    dc_idle();
    check_val("conf1_second_addr", dst_addr, 6);
    check_val("conf1_second_data", dst, 16'hBBBB);
    step();
    dc(1, 5, 16'hAAAA, 1, 6, 16'hBBBB, 0, 0, 0); step();
    dc_idle(); step();
    dc_idle();
    check_val("conf2_first_addr", dst_addr, 6);
    check_val("conf2_cnt", conf_cnt, 2);
    step();
    dc_idle();
    check_val("conf2_second_addr", dst_addr, 5);
    step();
    idle_cycles(2);

    // Same-address ordering
    dc(0, 0, 0, 1, 7, 16'h0001, 0, 0, 0); step();
    dc(1, 7, 16'h0002, 0, 0, 0, 0, 0, 0); step();
    dc_idle();
    check_val("same_first_data", dst, 16'h0001);
    step();
    dc_idle();
    check_val("same_second_data", dst, 16'h0002);
    check_val("same_r7_final", dut_rf[7], 16'h0002);
    step();
    idle_cycles(2);

    // Address-0 write
    dc(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    check_val("zero_stall_pre", stall, 0);
    step();
    dc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("zero_stall_held", stall, 0);
    check_val("zero_idle_held", idle, 0);
    step();
    dc_idle();
    check_val("zero_we", we, 0);
    check_val("zero_idle", idle, 1);
    step();

    // Halt with both entries full
    dc(1, 8, 16'h0808, 1, 9, 16'h0909, 0, 0, 0); step();
    dc(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 0);
    check_val("hlt_a_rdy", a_rdy, 0);
    check_val("hlt_b_rdy", b_rdy, 0);
    step();
    dc(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 0); step();
    dc(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 0); step();
    dc(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 0);
    check_val("hlt_idle", idle, 1);
    check_val("hlt_r8", dut_rf[8], 16'h0808);
    check_val("hlt_r9", dut_rf[9], 16'h0909);
    step();

    // Saturation: continuous conflicts
    for (int i = 0; i < 300; i++) begin
      dc(1, 1, 16'(i), 1, 2, 16'(i + 1000), 0, 0, 0); step();
    end
    dc_idle();
    check_val("sat_conf", conf_cnt, 255);
    step();
    idle_cycles(4);

    // Reset while both full and we=1
    dc(1, 10, 16'hA0A0, 1, 11, 16'hB0B0, 0, 0, 0); step();
    dc(1, 12, 16'hC0C0, 1, 13, 16'hD0D0, 0, 0, 0); step();
    dc_idle();
    check_val("mid_we_pre", we, 1);
    check_val("mid_busy_pre", idle, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("mid_rst_we", we, 0);
    check_val("mid_rst_idle", idle, 1);
    check_val("mid_rst_a_rdy", a_rdy, 0);
    check_val("mid_rst_conf", conf_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dc_idle();
      check_val("after_rst_we", we, 0);
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      dc($urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)), 16'($urandom),
         $urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)), 16'($urandom),
         $urandom_range(0, 9) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      step();
    end
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
